// File: rtl/instruction_fetch.sv
// instruction_fetch: sequences single-byte reads from synchronous program memory,
// drives PC increment/load strobes and assembles 1/2/3-byte instructions
// (opcode + little-endian operand) for a valid/ready handshake downstream.
// A branch redirect aborts any in-flight fetch and reloads the PC.
// Optional feature macro: FETCH_INSTR_COUNT_EN adds the instr_count port and
// a 16-bit wrapping accepted-instruction counter.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no fetch in progress; waits for halt low
// REQ   | issue one memory read and one PC increment
// CAP   | capture returned byte into opcode/operand, decide next byte
// DONE  | instruction presented; waits for downstream acceptance
module instruction_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    halt,
    input  logic [ADDR_WIDTH-1:0]   pc_value,
    output logic                    pc_enable,
    output logic                    pc_load,
    output logic [ADDR_WIDTH-1:0]   pc_load_value,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    redirect,
    input  logic [ADDR_WIDTH-1:0]   redirect_addr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_WIDTH-1:0]   instr_opcode,
    output logic [2*DATA_WIDTH-1:0] instr_operand,
    output logic [1:0]              instr_len,
    output logic [ADDR_WIDTH-1:0]   instr_pc
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [15:0]             instr_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              len_q, len_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
    logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0]             count_q, count_d;
`endif

    logic [1:0] len_decoded;
    logic [1:0] len_cur;
    logic       last_byte;
    logic       accept;

    // Length decode from the top two opcode bits of the byte being captured.
    always_comb begin
        len_decoded = 2'd1;
        case (mem_rdata[DATA_WIDTH-1 -: 2])
            2'b00:   len_decoded = 2'd1;
            2'b01:   len_decoded = 2'd2;
            default: len_decoded = 2'd3;
        endcase
        // On the opcode byte the stored length is stale, so use the fresh decode.
        len_cur   = (idx_q == 2'd0) ? len_decoded : len_q;
        last_byte = (idx_q == (len_cur - 2'd1));
        accept    = (state_q == S_DONE) && !redirect && instr_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect wins over everything.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (!halt) state_d = S_REQ;
                S_REQ:  state_d = S_CAP;
                S_CAP:  state_d = last_byte ? S_DONE : S_REQ;
                S_DONE: if (instr_ready) state_d = halt ? S_IDLE : S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs: strobes are killed in a redirect cycle.
    always_comb begin
        mem_addr      = pc_value;
        pc_load       = redirect;
        pc_load_value = redirect_addr;
        mem_rd_en     = (state_q == S_REQ) && !redirect;
        pc_enable     = (state_q == S_REQ) && !redirect;
        instr_valid   = (state_q == S_DONE) && !redirect;
        instr_opcode  = opcode_q;
        instr_operand = operand_q;
        instr_len     = len_q;
        instr_pc      = ipc_q;
`ifdef FETCH_INSTR_COUNT_EN
        instr_count   = count_q;
`endif
    end

    // Datapath next values: byte index, length, opcode/operand assembly, opcode PC.
    always_comb begin
        idx_d     = idx_q;
        len_d     = len_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ipc_d     = ipc_q;
`ifdef FETCH_INSTR_COUNT_EN
        count_d   = count_q;
`endif
        if (redirect) begin
            idx_d = 2'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (idx_q == 2'd0) begin
                        ipc_d     = pc_value;
                        operand_d = '0;
                    end
                end
                S_CAP: begin
                    case (idx_q)
                        2'd0: begin
                            opcode_d = mem_rdata;
                            len_d    = len_decoded;
                        end
                        2'd1:    operand_d[DATA_WIDTH-1:0] = mem_rdata;
                        default: operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_rdata;
                    endcase
                    if (!last_byte) idx_d = idx_q + 2'd1;
                end
                S_DONE: begin
                    if (accept) begin
                        idx_d = 2'd0;
`ifdef FETCH_INSTR_COUNT_EN
                        count_d = count_q + 16'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= 2'd0;
            len_q     <= 2'd0;
            opcode_q  <= '0;
            operand_q <= '0;
            ipc_q     <= '0;
`ifdef FETCH_INSTR_COUNT_EN
            count_q   <= 16'd0;
`endif
        end else begin
            idx_q     <= idx_d;
            len_q     <= len_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
`ifdef FETCH_INSTR_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and synchronous
// program memory. Define FETCH_INSTR_COUNT_EN to also check instr_count.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        halt;
    logic [15:0] pc_value;
    logic        pc_enable;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    logic [7:0]  mem [0:65535];
    int          hs_cnt;
    int          pen_cnt;
    int          vectors;
    int          miscompares;

    instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .halt          (halt),
        .pc_value      (pc_value),
        .pc_enable     (pc_enable),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_len     (instr_len),
        .instr_pc      (instr_pc)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model: load beats increment.
    always @(posedge clk) begin
        if (reset)          pc_value <= 16'h0000;
        else if (pc_load)   pc_value <= pc_load_value;
        else if (pc_enable) pc_value <= pc_value + 16'h0001;
    end

    // Synchronous program memory and event counters.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (reset) begin
            hs_cnt  <= 0;
            pen_cnt <= 0;
        end else begin
            if (instr_valid && instr_ready) hs_cnt <= hs_cnt + 1;
            if (pc_enable) pen_cnt <= pen_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_redirect(input logic [15:0] addr);
        redirect      = 1'b1;
        redirect_addr = addr;
        #1;
        chk("redir_pc_load", {31'd0, pc_load}, 32'd1);
        chk("redir_load_val", {16'd0, pc_load_value}, {16'd0, addr});
        chk("redir_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        step();
        redirect = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h05;
        mem[16'h0010] = 8'hC3; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
        mem[16'h0020] = 8'h41; mem[16'h0021] = 8'h7F;
        mem[16'h0030] = 8'h80; mem[16'h0031] = 8'h11; mem[16'h0032] = 8'h22;
        mem[16'h0200] = 8'h00;
        mem[16'h0040] = 8'h01; mem[16'h0041] = 8'h02;

        reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
        instr_ready = 1'b1; mem_rdata = 8'h00;
        step();
        step();
        chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
        chk("rst_rd_en",   {31'd0, mem_rd_en}, 32'd0);
        chk("rst_pc_en",   {31'd0, pc_enable}, 32'd0);
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rst_opcode",  {24'd0, instr_opcode}, 32'd0);
        chk("rst_operand", {16'd0, instr_operand}, 32'd0);
        chk("rst_len",     {30'd0, instr_len}, 32'd0);
        chk("rst_ipc",     {16'd0, instr_pc}, 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        chk("rst_count",   {16'd0, instr_count}, 32'd0);
`endif

        // 1-byte fetch from 0x0000: REQ in cycle 1, valid in cycle 3
        reset = 1'b0;
        step();
        chk("t1_req_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("t1_req_pc_en", {31'd0, pc_enable}, 32'd1);
        chk("t1_req_addr",  {16'd0, mem_addr}, 32'h0000);
        step();
        chk("t1_cap_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_cap_rd_en", {31'd0, mem_rd_en}, 32'd0);
        step();
        chk("t1_valid",   {31'd0, instr_valid}, 32'd1);
        chk("t1_opcode",  {24'd0, instr_opcode}, 32'h05);
        chk("t1_len",     {30'd0, instr_len}, 32'd1);
        chk("t1_ipc",     {16'd0, instr_pc}, 32'h0000);
        chk("t1_operand", {16'd0, instr_operand}, 32'h0000);
        chk("t1_pen_cnt", pen_cnt, 32'd1);
        chk("t1_pc",      {16'd0, pc_value}, 32'h0001);
        halt = 1'b1;
        step();
        chk("t1_idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("t1_hs", hs_cnt, 32'd1);
        step();
        chk("t1_halt_rd_en", {31'd0, mem_rd_en}, 32'd0);

        // 3-byte at 0x0010, halt raised mid-fetch
        do_redirect(16'h0010);
        halt = 1'b0;
        chk("t2_idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
        step();
        chk("t2_req_addr",  {16'd0, mem_addr}, 32'h0010);
        chk("t2_req_rd_en", {31'd0, mem_rd_en}, 32'd1);
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_inflight_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        step();
        chk("t2_valid",   {31'd0, instr_valid}, 32'd1);
        chk("t2_opcode",  {24'd0, instr_opcode}, 32'hC3);
        chk("t2_len",     {30'd0, instr_len}, 32'd3);
        chk("t2_operand", {16'd0, instr_operand}, 32'h1234);
        chk("t2_ipc",     {16'd0, instr_pc}, 32'h0010);
        chk("t2_pc",      {16'd0, pc_value}, 32'h0013);
        step();
        chk("t2_hs",         hs_cnt, 32'd2);
        chk("t2_idle_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_halt_rd_en", {31'd0, mem_rd_en}, 32'd0);
            step();
        end

        // 2-byte at 0x0020 held for 5 cycles with ready low
        do_redirect(16'h0020);
        halt = 1'b0;
        instr_ready = 1'b0;
        step();
        chk("t3_req_addr", {16'd0, mem_addr}, 32'h0020);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid",   {31'd0, instr_valid}, 32'd1);
            chk("t3_hold_opcode",  {24'd0, instr_opcode}, 32'h41);
            chk("t3_hold_operand", {16'd0, instr_operand}, 32'h007F);
            chk("t3_hold_len",     {30'd0, instr_len}, 32'd2);
            chk("t3_hold_ipc",     {16'd0, instr_pc}, 32'h0020);
            chk("t3_hold_rd_en",   {31'd0, mem_rd_en}, 32'd0);
            chk("t3_hold_pc_en",   {31'd0, pc_enable}, 32'd0);
            step();
        end
        chk("t3_pre_hs", hs_cnt, 32'd2);
        instr_ready = 1'b1;
        halt = 1'b1;
        chk("t3_acc_valid", {31'd0, instr_valid}, 32'd1);
        step();
        chk("t3_hs",         hs_cnt, 32'd3);
        chk("t3_idle_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect to 0x0200 during CAP of a 3-byte fetch at 0x0030
        do_redirect(16'h0030);
        halt = 1'b0;
        step();
        chk("t4_req_addr", {16'd0, mem_addr}, 32'h0030);
        step();
        instr_ready = 1'b0;
        do_redirect(16'h0200);
        chk("t4_idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
        step();
        chk("t4_req_addr2",  {16'd0, mem_addr}, 32'h0200);
        chk("t4_req_rd_en2", {31'd0, mem_rd_en}, 32'd1);
        step();
        step();
        chk("t4_valid",  {31'd0, instr_valid}, 32'd1);
        chk("t4_opcode", {24'd0, instr_opcode}, 32'h00);
        chk("t4_len",    {30'd0, instr_len}, 32'd1);
        chk("t4_ipc",    {16'd0, instr_pc}, 32'h0200);

        // Redirect with ready in DONE: squashed, no transfer
        instr_ready = 1'b1;
        do_redirect(16'h0300);
        instr_ready = 1'b0;
        halt = 1'b1;
        chk("t5_hs",         hs_cnt, 32'd3);
        chk("t5_idle_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        chk("t5_count", {16'd0, instr_count}, 32'd3);
`endif
        step();
        chk("t5_halt_rd_en", {31'd0, mem_rd_en}, 32'd0);

        // Back-to-back 1-byte instructions at 0x0040
        do_redirect(16'h0040);
        halt = 1'b0;
        instr_ready = 1'b1;
        step();
        step();
        step();
        chk("t6_valid1",  {31'd0, instr_valid}, 32'd1);
        chk("t6_opcode1", {24'd0, instr_opcode}, 32'h01);
        step();
        chk("t6_req_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("t6_req_addr",  {16'd0, mem_addr}, 32'h0041);
        step();
        step();
        chk("t6_valid2",  {31'd0, instr_valid}, 32'd1);
        chk("t6_opcode2", {24'd0, instr_opcode}, 32'h02);
        chk("t6_ipc2",    {16'd0, instr_pc}, 32'h0041);
        halt = 1'b1;
        step();
        chk("t6_hs", hs_cnt, 32'd5);
`ifdef FETCH_INSTR_COUNT_EN
        chk("t6_count", {16'd0, instr_count}, 32'd5);
`endif
        chk("t6_idle_valid", {31'd0, instr_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch sequencer between the program counter and the decode/control stage. Drives PC increment/load, issues single-byte reads to synchronous program memory, and assembles 1-, 2- or 3-byte instructions into opcode plus operand. Hands each completed instruction downstream over a valid/ready handshake, and aborts in-flight fetches on a branch redirect.

## Interface
- ADDR_WIDTH, 16, program address width; matches the PC width.
- DATA_WIDTH, 8, memory byte width; opcode width.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- halt  in  1  blocks the start of new fetches; any in-flight fetch completes.
- pc_value  in  ADDR_WIDTH  current PC output.
- pc_enable  out  1  PC increment strobe.
- pc_load  out  1  PC load strobe.
- pc_load_value  out  ADDR_WIDTH  PC load value.
- mem_addr  out  ADDR_WIDTH  read address; equals pc_value (combinational).
- mem_rd_en  out  1  read request; data returns the next cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
- redirect  in  1  branch taken; single-cycle pulse.
- redirect_addr  in  ADDR_WIDTH  branch target.
- instr_valid  out  1  instruction available.
- instr_ready  in  1  downstream accepts.
- instr_opcode  out  DATA_WIDTH  opcode byte.
- instr_operand  out  2*DATA_WIDTH  operand; little-endian, unused bytes zero.
- instr_len  out  2  byte count: 1, 2 or 3.
- instr_pc  out  ADDR_WIDTH  address of the opcode byte.
- instr_count  out  16  accepted-instruction count (FETCH_INSTR_COUNT_EN only).

## Operation
- States: IDLE, REQ, CAP, DONE. A byte index idx (0..2) and the decoded length len are held in registers.
- IDLE: if !halt, go to REQ; otherwise stay.
- REQ:
  - Assert mem_rd_en=1 and pc_enable=1 for one cycle.
  - If idx==0, latch instr_pc<=pc_value and clear instr_operand to 0.
  - Go to CAP.
- CAP: capture mem_rdata.
  - idx==0: store opcode; len decodes from opcode[7:6]: 00 gives 1, 01 gives 2, 1x gives 3.
  - idx==1: store operand[7:0].
  - idx==2: store operand[15:8].
  - If idx==len-1, go to DONE. Otherwise idx++ and go to REQ.
- DONE:
  - instr_valid = (state==DONE) && !redirect.
  - On instr_valid && instr_ready: idx<=0, then go to REQ if !halt, else IDLE.
  - All instr_* outputs are held stable while instr_valid=1 and not accepted.
- Redirect: highest priority, in any state.
  - pc_load=redirect and pc_load_value=redirect_addr (combinational).
  - mem_rd_en, pc_enable and instr_valid are forced 0 in the redirect cycle.
  - Next state is IDLE with idx<=0; the partial or completed instruction is discarded.
  - Redirect together with instr_ready in DONE: no transfer occurs and the instruction is squashed.
- PC arithmetic wraps modulo 2^ADDR_WIDTH (the PC's job). The fetcher adds no special handling at 0xFFFF→0x0000.

## Timing
- Reset values: state IDLE, idx 0, pc_enable 0, pc_load 0 (absent redirect), mem_rd_en 0, instr_valid 0, instr_opcode 0, instr_operand 0, instr_len 0, instr_pc 0, instr_count 0.
- Reset mid-fetch discards everything. The first REQ occurs in the cycle after IDLE with reset low.
- Latency from the first REQ cycle t: instr_valid at t+2 (1-byte), t+4 (2-byte), t+6 (3-byte).
- Back-to-back: handshake in cycle t, next REQ in t+1. Steady-state 1-byte throughput is 1 instruction per 3 cycles.
- Redirect in cycle t: IDLE at t+1, REQ at t+2 with pc_value=redirect_addr.
- Halt is sampled only in IDLE and on DONE exit.

## Configuration
- FETCH_INSTR_COUNT_EN defined:
  - Adds port instr_count, a 16-bit counter.
  - Increments on each instr_valid && instr_ready and wraps 0xFFFF→0.
  - Resets to 0. Squashed instructions are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with PC=0x0000; memory holds 0x05 at 0x0000, ready=1 → REQ in cycle 1, instr_valid cycle 3 with opcode 0x05, len 1, instr_pc 0x0000, operand 0x0000; pc_enable pulses exactly once.
- Memory 0x0010: 0xC3, 0x34, 0x12 → opcode 0xC3, len 3, operand 0x1234, instr_pc 0x0010; PC ends at 0x0013.
- 2-byte 0x41 0x7F with instr_ready=0 for 5 cycles → valid and outputs stable for 5 cycles, no mem_rd_en or pc_enable; accepted on the ready cycle.
- redirect=1, redirect_addr=0x0200 during CAP of a 3-byte fetch → pc_load=1, no instr_valid for the squashed instruction; next REQ with mem_addr 0x0200.
- redirect and instr_ready in the same DONE cycle → no transfer; instr_count unchanged (macro on).
- halt=1 asserted mid-fetch → current instruction completes and is accepted, then IDLE with no mem_rd_en until halt=0.
